// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: datapath word, decoded control word and small helpers.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [3:0]  lc3b_opcode;

   typedef struct packed {
      lc3b_opcode opcode;
      logic       load_regfile;
      logic       mem_read;
      logic       mem_write;
      logic       mem_byte;
      logic       mem_indirect;
   } lc3b_control_word;

   localparam lc3b_word WORD_ZERO = 16'h0000;

   function automatic lc3b_word sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;

   lc3b_types::lc3b_word dmem_address;
   lc3b_types::lc3b_word dmem_wdata;
   lc3b_types::lc3b_word dmem_rdata;
   logic                 dmem_read;
   logic                 dmem_write;
   logic                 dmem_resp;
   logic [1:0]           dmem_byte_enable;

   modport master (
      output dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
      input  dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
      output dmem_rdata, dmem_resp
   );

endinterface

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data accesses: store replication, byte enables, sign-extended byte loads.
module mem_byte_align
   import lc3b_types::*;
(
   input  logic       addr0_i,
   input  logic       byte_i,
   input  lc3b_word   rdata_i,
   input  lc3b_word   store_i,
   output logic [1:0] be_o,
   output lc3b_word   wdata_o,
   output lc3b_word   rdata_o
);

   lc3b_word store_rep;

   // A byte store drives its byte onto both lanes; the enable picks the lane.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign store_rep[gi*8 +: 8] = store_i[7:0];
      end
   endgenerate

   always_comb begin
      be_o    = 2'b11;
      wdata_o = store_i;
      rdata_o = rdata_i;
      if (byte_i) begin
         be_o    = addr0_i ? 2'b10 : 2'b01;
         wdata_o = store_rep;
         rdata_o = sext8(addr0_i ? rdata_i[15:8] : rdata_i[7:0]);
      end
   end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences direct and indirect data accesses, stalls the pipe while busy,
// and registers load data for the MEM/WB latch.
module mem_stage
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             reset,
   input  lc3b_word         pc_in,
   input  lc3b_word         instruction_in,
   input  lc3b_word         aluval_in,
   input  lc3b_word         srcdata_in,
   input  lc3b_control_word control_in,
   mem_stage_if.master      dmem,
   output lc3b_word         pc_out,
   output lc3b_word         instruction_out,
   output lc3b_word         aluval_out,
   output lc3b_control_word control_out,
   output lc3b_word         rdata_out,
   output logic             stall_out
);

   typedef enum logic [1:0] {S_IDLE, S_IND, S_ACC, S_DONE} state_t;

   state_t     state_q, state_d;
   lc3b_word   ptr_q, ptr_d;
   lc3b_word   rdata_q, rdata_d;

   logic       memop, is_write;
   lc3b_word   base_addr;
   logic [1:0] al_be;
   lc3b_word   al_wdata, al_rdata;

   logic       rd_s, wr_s;
   lc3b_word   addr_s, wdata_s;
   logic [1:0] be_s;

   assign memop    = control_in.mem_read | control_in.mem_write;
   assign is_write = control_in.mem_write;
   assign base_addr = (state_q == S_ACC && control_in.mem_indirect) ? ptr_q : aluval_in;

   mem_byte_align u_align (
      .addr0_i (base_addr[0]),
      .byte_i  (control_in.mem_byte),
      .rdata_i (dmem.dmem_rdata),
      .store_i (srcdata_in),
      .be_o    (al_be),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= WORD_ZERO;
         rdata_q <= WORD_ZERO;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes depend only on state and the held EX/MEM fields, never on dmem_resp.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rdata_d   = rdata_q;
      rd_s      = 1'b0;
      wr_s      = 1'b0;
      addr_s    = WORD_ZERO;
      wdata_s   = WORD_ZERO;
      be_s      = 2'b00;
      stall_out = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_out = memop;
            if (memop) state_d = control_in.mem_indirect ? S_IND : S_ACC;
         end
         S_IND: begin
            stall_out = 1'b1;
            rd_s      = 1'b1;
            addr_s    = {aluval_in[15:1], 1'b0};
            be_s      = 2'b11;
            if (dmem.dmem_resp) begin
               ptr_d   = dmem.dmem_rdata;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            stall_out = 1'b1;
            addr_s    = control_in.mem_byte ? base_addr : {base_addr[15:1], 1'b0};
            if (is_write) begin
               wr_s    = 1'b1;
               wdata_s = al_wdata;
               be_s    = al_be;
            end else begin
               rd_s = 1'b1;
               be_s = 2'b11;
            end
            if (dmem.dmem_resp) begin
               if (!is_write) rdata_d = al_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dmem.dmem_read        = rd_s;
   assign dmem.dmem_write       = wr_s;
   assign dmem.dmem_address     = addr_s;
   assign dmem.dmem_wdata       = wdata_s;
   assign dmem.dmem_byte_enable = be_s;

   assign pc_out          = pc_in;
   assign instruction_out = instruction_in;
   assign aluval_out      = aluval_in;
   assign control_out     = control_in;
   assign rdata_out       = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner cases, and
// randomized operations against a word-array memory model.
module tb_mem_stage;
   import lc3b_types::*;

   logic             clk = 1'b0;
   logic             reset;
   lc3b_word         pc_in, instruction_in, aluval_in, srcdata_in;
   lc3b_control_word control_in;
   lc3b_word         pc_out, instruction_out, aluval_out, rdata_out;
   lc3b_control_word control_out;
   logic             stall_out;

   mem_stage_if dmem_if();

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .instruction_in  (instruction_in),
      .aluval_in       (aluval_in),
      .srcdata_in      (srcdata_in),
      .control_in      (control_in),
      .dmem            (dmem_if),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .aluval_out      (aluval_out),
      .control_out     (control_out),
      .rdata_out       (rdata_out),
      .stall_out       (stall_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   lc3b_word mem [0:32767];

   int         res_stalls, res_nacc;
   logic       res_stable, res_timeout;
   lc3b_word   acc_addr [2];
   lc3b_word   acc_wdata [2];
   logic [1:0] acc_be [2];
   logic       acc_wr [2];
   lc3b_word   model_rdata;

   typedef struct {
      logic r, w, b, ind;
      lc3b_word alu, src;
      int l1, l2;
      int exp_stalls, exp_nacc;
      lc3b_word exp_addr;
      logic [1:0] exp_be;
      logic exp_wr;
      lc3b_word exp_wdata, exp_rdata;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s op%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   function automatic lc3b_control_word mkctl(input logic r, w, b, ind);
      lc3b_control_word c;
      c = '0;
      c.opcode = 4'(r ? 4'h6 : (w ? 4'h7 : 4'h1));
      c.load_regfile = r;
      c.mem_read = r;
      c.mem_write = w;
      c.mem_byte = b;
      c.mem_indirect = ind;
      return c;
   endfunction

   task automatic apply_write(input lc3b_word a, input logic [1:0] be, input lc3b_word wd);
      if (be[0]) mem[a[15:1]][7:0]  = wd[7:0];
      if (be[1]) mem[a[15:1]][15:8] = wd[15:8];
   endtask

   // Called at a falling edge; plays the memory with the given latencies until the op retires.
   task automatic run_op(input int idx, input lc3b_control_word c, input lc3b_word alu, input lc3b_word src,
                         input int l1, input int l2);
      int strobe_cnt, lat;
      logic st;
      logic [50:0] snap, cur;
      pc_in = 16'($urandom);
      instruction_in = 16'($urandom);
      control_in = c;
      aluval_in = alu;
      srcdata_in = src;
      res_stalls = 0; res_nacc = 0; res_stable = 1'b1; res_timeout = 1'b1;
      strobe_cnt = 0; lat = l1; snap = '0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         #1;
         if (cyc == 0) begin
            chk("pc_pass", idx, pc_out, pc_in);
            chk("ins_pass", idx, instruction_out, instruction_in);
            chk("alu_pass", idx, aluval_out, alu);
            chk("ctl_pass", idx, control_out, c);
         end
         if (dmem_if.dmem_read || dmem_if.dmem_write) begin
            cur = {dmem_if.dmem_address, dmem_if.dmem_wdata, dmem_if.dmem_byte_enable,
                   dmem_if.dmem_read, dmem_if.dmem_write, 15'd0};
            if (strobe_cnt == 0) snap = cur;
            else if (cur !== snap) res_stable = 1'b0;
            strobe_cnt++;
            if (strobe_cnt == lat) begin
               dmem_if.dmem_resp  = 1'b1;
               dmem_if.dmem_rdata = mem[dmem_if.dmem_address[15:1]];
               if (res_nacc < 2) begin
                  acc_addr[res_nacc]  = dmem_if.dmem_address;
                  acc_wdata[res_nacc] = dmem_if.dmem_wdata;
                  acc_be[res_nacc]    = dmem_if.dmem_byte_enable;
                  acc_wr[res_nacc]    = dmem_if.dmem_write;
               end
               res_nacc++;
               strobe_cnt = 0;
               lat = l2;
            end else begin
               dmem_if.dmem_resp  = 1'b0;
               dmem_if.dmem_rdata = 16'($urandom);
            end
         end else begin
            dmem_if.dmem_resp  = 1'b0;
            dmem_if.dmem_rdata = 16'($urandom);
         end
         st = stall_out;
         if (st) res_stalls++;
         @(posedge clk);
         @(negedge clk);
         if (!st) begin
            res_timeout = 1'b0;
            break;
         end
      end
      dmem_if.dmem_resp = 1'b0;
   endtask

   task automatic check_op(input int idx, input logic ind, input logic wr, input lc3b_word alu,
                           input int es, input int en, input lc3b_word ea, input logic [1:0] eb,
                           input lc3b_word ew, input lc3b_word er);
      int k;
      chk("timeout", idx, res_timeout, 0);
      chk("stalls", idx, res_stalls, es);
      chk("naccess", idx, res_nacc, en);
      chk("stable", idx, res_stable, 1);
      if (en > 0 && res_nacc == en) begin
         k = en - 1;
         if (ind) begin
            chk("ptr_addr", idx, acc_addr[0], {alu[15:1], 1'b0});
            chk("ptr_be", idx, acc_be[0], 2'b11);
            chk("ptr_isrd", idx, acc_wr[0], 0);
         end
         chk("addr", idx, acc_addr[k], ea);
         chk("be", idx, acc_be[k], eb);
         chk("iswrite", idx, acc_wr[k], wr);
         if (wr) chk("wdata", idx, acc_wdata[k], ew);
      end
      chk("rdata", idx, rdata_out, er);
   endtask

   initial begin
      lc3b_control_word c;
      logic r, w, b, ind, memop;
      lc3b_word alu, src, ptr, base, ea, ew, word, er;
      logic [1:0] eb;
      logic [7:0] bt;
      int l1, l2, es, en, sel;

      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 64; i++) mem[16'h0800 + i] = 16'h1000 + 16'($urandom_range(0, 127));
      mem[16'h3002 >> 1] = 16'hBEEF;
      mem[16'h4000 >> 1] = 16'h80FF;
      mem[16'h5000 >> 1] = 16'h6000;
      mem[16'h6000 >> 1] = 16'h00AA;
      mem[16'h5800 >> 1] = 16'h7000;

      //           r  w  b  i  alu       src       l1 l2 st na addr      be     wr wdata     rdata
      vt[0]  = '{1, 0, 0, 0, 16'h3002, 16'h0000, 1, 1, 2, 1, 16'h3002, 2'b11, 0, 16'h0000, 16'hBEEF};
      vt[1]  = '{1, 0, 1, 0, 16'h4001, 16'h0000, 1, 1, 2, 1, 16'h4001, 2'b11, 0, 16'h0000, 16'hFF80};
      vt[2]  = '{0, 1, 1, 0, 16'h4001, 16'h1234, 1, 1, 2, 1, 16'h4001, 2'b10, 1, 16'h3434, 16'hFF80};
      vt[3]  = '{1, 0, 1, 0, 16'h4000, 16'h0000, 2, 1, 3, 1, 16'h4000, 2'b11, 0, 16'h0000, 16'hFFFF};
      vt[4]  = '{1, 0, 1, 0, 16'h4001, 16'h0000, 1, 1, 2, 1, 16'h4001, 2'b11, 0, 16'h0000, 16'h0034};
      vt[5]  = '{0, 1, 1, 0, 16'h4000, 16'hAB80, 1, 1, 2, 1, 16'h4000, 2'b01, 1, 16'h8080, 16'h0034};
      vt[6]  = '{1, 0, 0, 0, 16'h4000, 16'h0000, 4, 1, 5, 1, 16'h4000, 2'b11, 0, 16'h0000, 16'h3480};
      vt[7]  = '{1, 0, 0, 0, 16'h3003, 16'h0000, 1, 1, 2, 1, 16'h3002, 2'b11, 0, 16'h0000, 16'hBEEF};
      vt[8]  = '{1, 0, 0, 1, 16'h5000, 16'h0000, 3, 3, 7, 2, 16'h6000, 2'b11, 0, 16'h0000, 16'h00AA};
      vt[9]  = '{0, 1, 0, 1, 16'h5800, 16'h5555, 1, 2, 4, 2, 16'h7000, 2'b11, 1, 16'h5555, 16'h00AA};
      vt[10] = '{0, 0, 0, 0, 16'h1234, 16'h9999, 1, 1, 0, 0, 16'h0000, 2'b11, 0, 16'h0000, 16'h00AA};
      vt[11] = '{1, 1, 0, 0, 16'h2001, 16'h1111, 1, 1, 2, 1, 16'h2000, 2'b11, 1, 16'h1111, 16'h00AA};
      vt[12] = '{1, 0, 1, 1, 16'h5000, 16'h0000, 1, 1, 3, 2, 16'h6000, 2'b11, 0, 16'h0000, 16'hFFAA};

      reset = 1'b1;
      control_in = '0;
      pc_in = '0; instruction_in = '0; aluval_in = '0; srcdata_in = '0;
      dmem_if.dmem_resp = 1'b0;
      dmem_if.dmem_rdata = '0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_read", 0, dmem_if.dmem_read, 0);
      chk("rst_write", 0, dmem_if.dmem_write, 0);
      chk("rst_addr", 0, dmem_if.dmem_address, 16'h0000);
      chk("rst_stall", 0, stall_out, 0);
      chk("rst_rdata", 0, rdata_out, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(i, mkctl(vt[i].r, vt[i].w, vt[i].b, vt[i].ind), vt[i].alu, vt[i].src, vt[i].l1, vt[i].l2);
         check_op(i, vt[i].ind, vt[i].w, vt[i].alu, vt[i].exp_stalls, vt[i].exp_nacc,
                  vt[i].exp_addr, vt[i].exp_be, vt[i].exp_wdata, vt[i].exp_rdata);
         if (vt[i].w) apply_write(vt[i].exp_addr, vt[i].exp_be, vt[i].exp_wdata);
         $display("op%0d r=%0d w=%0d b=%0d ind=%0d alu=%h stalls=%0d rdata=%h",
                  i, vt[i].r, vt[i].w, vt[i].b, vt[i].ind, vt[i].alu, res_stalls, rdata_out);
      end
      model_rdata = 16'hFFAA;

      // Reset while the final access is waiting on a pending response.
      control_in = mkctl(1, 0, 0, 0);
      aluval_in = 16'h3002;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("acc_read", 100, dmem_if.dmem_read, 1);
      dmem_if.dmem_resp = 1'b1;
      dmem_if.dmem_rdata = 16'h1234;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_read", 100, dmem_if.dmem_read, 0);
      chk("mid_rst_addr", 100, dmem_if.dmem_address, 16'h0000);
      chk("mid_rst_rdata", 100, rdata_out, 16'h0000);
      chk("mid_rst_stall", 100, stall_out, 1);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_rdata", 100, rdata_out, 16'h0000);
      reset = 1'b0;
      control_in = '0;
      #1;
      chk("stray_stall", 101, stall_out, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("stray_read", 101, dmem_if.dmem_read, 0);
      chk("stray_write", 101, dmem_if.dmem_write, 0);
      chk("stray_stall2", 101, stall_out, 0);
      chk("stray_rdata", 101, rdata_out, 16'h0000);
      dmem_if.dmem_resp = 1'b0;
      @(negedge clk);
      run_op(102, mkctl(1, 0, 0, 0), 16'h3002, 16'h0000, 1, 1);
      check_op(102, 0, 0, 16'h3002, 2, 1, 16'h3002, 2'b11, 16'h0000, 16'hBEEF);
      $display("op102 post-reset LDR stalls=%0d rdata=%h", res_stalls, rdata_out);
      model_rdata = 16'hBEEF;

      for (int i = 200; i < 260; i++) begin
         sel = $urandom_range(0, 5);
         b = 1'($urandom_range(0, 1));
         ind = 1'($urandom_range(0, 1));
         r = (sel == 1 || sel == 3 || sel == 5);
         w = (sel == 2 || sel == 4 || sel == 5);
         if (sel == 3 || sel == 4) ind = 1'b1;
         if (sel == 1 || sel == 2) ind = 1'b0;
         alu = 16'h1000 + 16'($urandom_range(0, 127));
         src = 16'($urandom);
         l1 = $urandom_range(1, 4);
         l2 = $urandom_range(1, 4);
         memop = r | w;
         ptr = mem[alu[15:1]];
         base = ind ? ptr : alu;
         ea = b ? base : {base[15:1], 1'b0};
         eb = (w && b) ? (base[0] ? 2'b10 : 2'b01) : 2'b11;
         ew = b ? {src[7:0], src[7:0]} : src;
         word = mem[base[15:1]];
         bt = base[0] ? word[15:8] : word[7:0];
         if (memop && !w) model_rdata = b ? 16'($signed(bt)) : word;
         er = model_rdata;
         es = memop ? 1 + l1 + (ind ? l2 : 0) : 0;
         en = memop ? (ind ? 2 : 1) : 0;
         c = mkctl(r, w, b, ind);
         run_op(i, c, alu, src, l1, l2);
         check_op(i, ind & memop, w, alu, es, en, ea, eb, ew, er);
         if (memop && w) apply_write(ea, eb, ew);
         $display("op%0d r=%0d w=%0d b=%0d ind=%0d alu=%h l=%0d/%0d stalls=%0d rdata=%h",
                  i, r, w, b, ind, alu, l1, l2, res_stalls, rdata_out);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
